// File: rtl/stereo_frame_sequencer.sv
// Frame-level sequencer for the stereo pipeline: aligns left/right streams on SOF,
// paces pixel strobes at 1/PIXEL_DIV, flushes pipeline latency, commits coefficients.
//
// state    | meaning
// IDLE     | pipeline off, inputs held
// WAIT_SOF | dropping non-SOF words until both sides present SOF
// ACTIVE   | accepting real pixels on slot cycles
// FLUSH    | emitting padding strobes to drain pipeline latency
// DONE     | one-cycle end-of-frame marker
module stereo_frame_sequencer #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int PIXEL_DIV    = 8,
  parameter int FLUSH_PIXELS = 2048,
  parameter int X_W          = 10,
  parameter int Y_W          = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           continuous,
  input  logic           left_valid,
  input  logic           right_valid,
  input  logic           left_sof,
  input  logic           right_sof,
  output logic           left_ready,
  output logic           right_ready,
  output logic           pipe_en,
  output logic           pixel_en,
  output logic           pad_sel,
  output logic [X_W-1:0] x_cnt,
  output logic [Y_W-1:0] y_cnt,
  input  logic           cfg_pending,
  output logic           cfg_commit,
  output logic           busy,
  output logic           frame_done,
  output logic           sync_err
);

  localparam int DIV_W = $clog2(PIXEL_DIV);
  localparam int FL_W  = 12;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(IMAGE_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMAGE_HEIGHT - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_PIXELS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_next;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic             sync_err_q, sync_err_d;
  logic             pipe_en_q, pipe_en_d;
  logic             pad_sel_q, pad_sel_d;
  logic             cfg_commit_q, cfg_commit_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             slot, both_valid, any_sof, at_origin, commit_arm;

  assign slot       = (div_q == '0);
  assign both_valid = left_valid && right_valid;
  assign any_sof    = left_sof || right_sof;
  assign at_origin  = (x_q == '0) && (y_q == '0);
  assign div_next   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    x_d         = x_q;
    y_d         = y_q;
    flush_d     = flush_q;
    sync_err_d  = sync_err_q;
    pixel_en    = 1'b0;
    left_ready  = 1'b0;
    right_ready = 1'b0;
    commit_arm  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT;
          sync_err_d = 1'b0;
        end
      end
      S_WAIT: begin
        left_ready  = left_valid && !left_sof;
        right_ready = right_valid && !right_sof;
        if (left_valid && left_sof && right_valid && right_sof) begin
          state_d    = S_ACTIVE;
          div_d      = '0;
          commit_arm = cfg_pending;
        end
      end
      S_ACTIVE: begin
        if (slot && both_valid) begin
          left_ready  = 1'b1;
          right_ready = 1'b1;
          // A stray SOF means the streams slipped; discard the words and realign.
          if (any_sof && !at_origin) begin
            sync_err_d = 1'b1;
            state_d    = S_WAIT;
            x_d        = '0;
            y_d        = '0;
            div_d      = '0;
          end else begin
            pixel_en = 1'b1;
            div_d    = div_next;
            if (x_q == X_LAST) begin
              x_d = '0;
              if (y_q == Y_LAST) begin
                y_d     = '0;
                state_d = S_FLUSH;
                flush_d = FL_LAST;
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end else if (!slot) begin
          div_d = div_next;
        end
      end
      S_FLUSH: begin
        div_d = div_next;
        if (slot) begin
          pixel_en = 1'b1;
          if (flush_q == '0) begin
            state_d = S_DONE;
            div_d   = '0;
          end else begin
            flush_d = flush_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = continuous ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      div_d      = '0;
      x_d        = '0;
      y_d        = '0;
      flush_d    = '0;
      sync_err_d = sync_err_q;
      commit_arm = 1'b0;
    end
  end

  always_comb begin
    pipe_en_d    = (state_d != S_IDLE);
    busy_d       = (state_d != S_IDLE);
    pad_sel_d    = (state_d == S_FLUSH);
    frame_done_d = (state_d == S_DONE);
    cfg_commit_d = commit_arm || (cfg_pending && (state_d == S_DONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      flush_q      <= '0;
      sync_err_q   <= 1'b0;
      pipe_en_q    <= 1'b0;
      pad_sel_q    <= 1'b0;
      cfg_commit_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      x_q          <= x_d;
      y_q          <= y_d;
      flush_q      <= flush_d;
      sync_err_q   <= sync_err_d;
      pipe_en_q    <= pipe_en_d;
      pad_sel_q    <= pad_sel_d;
      cfg_commit_q <= cfg_commit_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign pipe_en    = pipe_en_q;
  assign pad_sel    = pad_sel_q;
  assign x_cnt      = x_q;
  assign y_cnt      = y_q;
  assign cfg_commit = cfg_commit_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// Scoreboard bench for stereo_frame_sequencer with W=4, H=2, DIV=2, FLUSH=3.
module tb_stereo_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic       left_valid = 1'b0, right_valid = 1'b0;
  logic       left_sof = 1'b0, right_sof = 1'b0;
  logic       cfg_pending = 1'b0;
  logic       left_ready, right_ready, pipe_en, pixel_en, pad_sel;
  logic [9:0] x_cnt;
  logic [8:0] y_cnt;
  logic       cfg_commit, busy, frame_done, sync_err;

  stereo_frame_sequencer #(
    .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .PIXEL_DIV(2), .FLUSH_PIXELS(3), .X_W(10), .Y_W(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continuous(continuous),
    .left_valid(left_valid), .right_valid(right_valid),
    .left_sof(left_sof), .right_sof(right_sof),
    .left_ready(left_ready), .right_ready(right_ready),
    .pipe_en(pipe_en), .pixel_en(pixel_en), .pad_sel(pad_sel),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .cfg_pending(cfg_pending), .cfg_commit(cfg_commit),
    .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pad;
    int x;
    int y;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  bit   lsrc[$];
  bit   rsrc[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, last_ev_cyc = 0;
  int   strobe_cnt = 0, fd_cnt = 0, cc_cnt = 0, ldrop = 0, rdrop = 0;
  int   rstall = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source model: streams presented from queues, consumed on ready.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    left_valid  = (lsrc.size() > 0);
    left_sof    = (lsrc.size() > 0) ? lsrc[0] : 1'b0;
    right_valid = (rsrc.size() > 0) && (rstall == 0);
    right_sof   = (rsrc.size() > 0) ? rsrc[0] : 1'b0;
    if (rstall > 0) rstall--;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (pixel_en) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_pad_sel", int'(pad_sel), int'(e.pad));
          chk("strobe_x", int'(x_cnt), e.x);
          chk("strobe_y", int'(y_cnt), e.y);
          chk("strobe_ready", int'({left_ready, right_ready}), e.pad ? 0 : 3);
          if (e.gap != 0) chk("strobe_gap", cyc - last_ev_cyc, e.gap);
        end
        last_ev_cyc = cyc;
      end
      if (left_ready && !pixel_en) ldrop++;
      if (right_ready && !pixel_en) rdrop++;
      if (left_ready && lsrc.size() > 0) void'(lsrc.pop_front());
      if (right_ready && rsrc.size() > 0) void'(rsrc.pop_front());
      if (frame_done) fd_cnt++;
      if (cfg_commit) begin
        cc_cnt++;
        chk("commit_in_done_cycle", int'(frame_done), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit with_abort);
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = with_abort;
    last_ev_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic load_words(input int lpre);
    for (int i = 0; i < lpre; i++) lsrc.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      lsrc.push_back(i == 0);
      rsrc.push_back(i == 0);
    end
  endtask

  task automatic push_frame(input int first_gap, input int stall_idx, input int stall_gap);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.pad = 1'b0;
      e.x   = i % 4;
      e.y   = i / 4;
      e.gap = (i == 0) ? first_gap : ((i == stall_idx) ? stall_gap : 2);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.pad = 1'b1;
      e.x   = 0;
      e.y   = 0;
      e.gap = 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int n0 = fd_cnt;
    int k  = 0;
    while (fd_cnt == n0 && k < 200) begin
      tick();
      k++;
    end
    chk(name, fd_cnt - n0, 1);
    tick();
  endtask

  task automatic wait_strobes(input int target);
    int k = 0;
    while (strobe_cnt < target && k < 200) begin
      tick();
      k++;
    end
    chk("strobe_count_reached", strobe_cnt >= target, 1);
  endtask

  initial begin
    int base, ld0, rd0, fd0, cc0;

    // Reset state
    tick();
    chk("reset_flags", int'({pipe_en, pixel_en, pad_sel, left_ready, right_ready,
                             cfg_commit, frame_done, busy, sync_err}), 0);
    chk("reset_xy", int'(x_cnt) + int'(y_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Aligned frame
    ld0 = ldrop; rd0 = rdrop; fd0 = fd_cnt;
    load_words(0);
    push_frame(2, -1, 0);
    pulse_start(1'b0);
    chk("aligned_busy", int'(busy), 1);
    chk("aligned_pipe_en", int'(pipe_en), 1);
    wait_done("aligned_frame_done");
    chk("aligned_idle_busy", int'(busy), 0);
    chk("aligned_idle_pipe_en", int'(pipe_en), 0);
    chk("aligned_no_drops", (ldrop - ld0) + (rdrop - rd0), 0);
    chk("aligned_strobes_left", exp_q.size(), 0);
    repeat (3) tick();
    chk("aligned_single_done", fd_cnt - fd0, 1);

    // Misaligned SOF
    ld0 = ldrop; rd0 = rdrop;
    load_words(3);
    push_frame(5, -1, 0);
    pulse_start(1'b0);
    wait_done("misaligned_frame_done");
    chk("misaligned_left_drops", ldrop - ld0, 3);
    chk("misaligned_right_drops", rdrop - rd0, 0);
    chk("misaligned_strobes_left", exp_q.size(), 0);

    // Stall on right stream
    base = strobe_cnt;
    load_words(0);
    push_frame(2, 2, 6);
    pulse_start(1'b0);
    wait_strobes(base + 2);
    rstall = 5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pixel_en", int'(pixel_en), 0);
      chk("stall_ready", int'({left_ready, right_ready}), 0);
      chk("stall_x_frozen", int'(x_cnt), 2);
    end
    wait_done("stall_frame_done");
    chk("stall_total_accepts", strobe_cnt - base, 11);
    chk("stall_strobes_left", exp_q.size(), 0);

    // Mid-frame SOF at (2,0)
    ld0 = ldrop; rd0 = rdrop; fd0 = fd_cnt;
    lsrc.push_back(1'b1); lsrc.push_back(1'b0); lsrc.push_back(1'b1);
    rsrc.push_back(1'b1); rsrc.push_back(1'b0); rsrc.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.pad = 1'b0; e.x = i; e.y = 0; e.gap = 2;
      exp_q.push_back(e);
    end
    pulse_start(1'b0);
    begin
      int k = 0;
      while (!sync_err && k < 100) begin
        tick();
        k++;
      end
    end
    chk("midsof_sync_err", int'(sync_err), 1);
    chk("midsof_xy_cleared", int'(x_cnt) + int'(y_cnt), 0);
    chk("midsof_still_busy", int'(busy), 1);
    chk("midsof_no_done", fd_cnt - fd0, 0);
    chk("midsof_words_dropped", (ldrop - ld0) + (rdrop - rd0), 2);
    chk("midsof_strobes_left", exp_q.size(), 0);
    push_frame(0, -1, 0);
    load_words(0);
    wait_done("midsof_clean_frame_done");
    chk("midsof_sync_err_sticky", int'(sync_err), 1);
    chk("midsof_clean_strobes_left", exp_q.size(), 0);

    // Coefficient commit at frame end
    base = strobe_cnt; cc0 = cc_cnt;
    load_words(0);
    push_frame(2, -1, 0);
    pulse_start(1'b0);
    tick();
    chk("start_clears_sync_err", int'(sync_err), 0);
    wait_strobes(base + 3);
    cfg_pending = 1'b1;
    repeat (2) tick();
    chk("commit_not_mid_frame", cc_cnt - cc0, 0);
    wait_done("commit_frame_done");
    cfg_pending = 1'b0;
    chk("commit_pulse_count", cc_cnt - cc0, 1);
    chk("commit_strobes_left", exp_q.size(), 0);

    // Abort together with start in IDLE
    pulse_start(1'b1);
    tick();
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_pipe_en", int'(pipe_en), 0);

    // Abort during FLUSH
    fd0 = fd_cnt;
    load_words(0);
    push_frame(2, -1, 0);
    while (exp_q.size() > 9) void'(exp_q.pop_back());
    pulse_start(1'b0);
    begin
      int k = 0;
      while (!pad_sel && k < 100) begin
        tick();
        k++;
      end
    end
    chk("flush_entered", int'(pad_sel), 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    tick();
    chk("abort_flush_busy", int'(busy), 0);
    chk("abort_flush_pad_sel", int'(pad_sel), 0);
    repeat (4) tick();
    chk("abort_flush_no_done", fd_cnt - fd0, 0);
    chk("abort_flush_strobes_left", exp_q.size(), 0);

    // Asynchronous reset mid-ACTIVE
    base = strobe_cnt;
    load_words(0);
    push_frame(2, -1, 0);
    pulse_start(1'b0);
    wait_strobes(base + 3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", int'({pipe_en, pixel_en, pad_sel, left_ready, right_ready,
                                   cfg_commit, frame_done, busy, sync_err}), 0);
    chk("async_reset_xy", int'(x_cnt) + int'(y_cnt), 0);
    exp_q.delete();
    lsrc.delete();
    rsrc.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("after_reset_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
